speculative_output_channel_credit_tracker: RTL

- Tracks, per output channel, writes in flight across a parametrised number of downstream pipeline stages.
- Combines those counts with live channel-buffer occupancy to produce the full status the trigger stage uses to gate issue.
- Sits between the trigger/issue stage and the output channel buffers.
- Generalises the single-stage pessimistic updater: depth-aware credit accounting, multi-stage tracking, stall hold and quash recovery, with legacy pessimistic mode selectable.

---
 rtl/speculative_output_channel_credit_tracker_pkg.sv | 18 +
 rtl/speculative_output_channel_credit_tracker_inflight_counter.sv | 63 ++++++
 rtl/speculative_output_channel_credit_tracker.sv | 118 +++++++++++
 3 files changed

// File: rtl/speculative_output_channel_credit_tracker_pkg.sv
// ---------------------------------------------------------------------------
// speculative_output_channel_credit_tracker_pkg: shared control constants/types
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package speculative_output_channel_credit_tracker_pkg;

  localparam int TIA_NUM_OUTPUT_CHANNELS         = 4;
  localparam int TIA_OCI_WIDTH                   = TIA_NUM_OUTPUT_CHANNELS;
  localparam int TIA_MAX_PIPELINE_STAGES         = 8;
  localparam int TIA_OUTPUT_CHANNEL_BUFFER_DEPTH = 2;

  typedef logic [TIA_NUM_OUTPUT_CHANNELS-1:0] output_channel_oci_t;

endpackage

`default_nettype wire

// File: rtl/speculative_output_channel_credit_tracker_inflight_counter.sv
// ---------------------------------------------------------------------------
// output_channel_inflight_counter: per-channel in-flight write counter and full bit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module output_channel_inflight_counter #(
  parameter int CNT_W            = 2,
  parameter int OCC_W            = 2,
  parameter int SUM_W            = 3,
  parameter int DEPTH            = 2,
  parameter int PESSIMISTIC_MODE = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             quash_load,
  input  logic             quash_value,
  input  logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             over
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [SUM_W-1:0] sum;

  always_comb begin
    count_d = count_q;
    if (quash_load) begin
      count_d = CNT_W'(quash_value);
    end else begin
      count_d = count_q + CNT_W'(inc) - CNT_W'(dec);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Registered count only: the same-cycle issue never feeds back into full.
  assign sum  = SUM_W'(occupancy) + SUM_W'(count_q);
  assign over = (occupancy > OCC_W'(DEPTH)) | (sum > SUM_W'(DEPTH));

  generate
    if (PESSIMISTIC_MODE != 0) begin : g_pessimistic
      assign full = (occupancy == OCC_W'(DEPTH)) | (count_q != '0);
    end else begin : g_exact
      assign full = (sum >= SUM_W'(DEPTH));
    end
  endgenerate

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/speculative_output_channel_credit_tracker.sv
// ---------------------------------------------------------------------------
// speculative_output_channel_credit_tracker: multi-stage in-flight write tracking
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module speculative_output_channel_credit_tracker
  import speculative_output_channel_credit_tracker_pkg::*;
#(
  parameter int NUM_OUTPUT_CHANNELS  = TIA_NUM_OUTPUT_CHANNELS,
  parameter int NUM_STAGES           = 2,
  parameter int CHANNEL_BUFFER_DEPTH = 2,
  parameter int PESSIMISTIC_MODE     = 0,
  localparam int OCC_W = $clog2(CHANNEL_BUFFER_DEPTH + 1),
  localparam int CNT_W = $clog2(NUM_STAGES + 1),
  localparam int SUM_W = $clog2(CHANNEL_BUFFER_DEPTH + NUM_STAGES + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 issue_valid,
  input  logic [NUM_OUTPUT_CHANNELS-1:0]       issue_oci,
  input  logic                                 stall,
  input  logic                                 quash,
  input  logic [NUM_OUTPUT_CHANNELS*OCC_W-1:0] output_channel_occupancy,
  output logic [NUM_OUTPUT_CHANNELS-1:0]       output_channel_full_status,
  output logic [NUM_OUTPUT_CHANNELS*CNT_W-1:0] inflight_count,
  output logic                                 overflow_error
);

  localparam int LAST = NUM_STAGES - 1;

  generate
    if (NUM_STAGES < 1 || NUM_STAGES > TIA_MAX_PIPELINE_STAGES) begin : g_bad_stages
      $error("NUM_STAGES out of range");
    end
    if (CHANNEL_BUFFER_DEPTH < 1) begin : g_bad_depth
      $error("CHANNEL_BUFFER_DEPTH must be at least 1");
    end
  endgenerate

  logic [NUM_STAGES-1:0][NUM_OUTPUT_CHANNELS-1:0] entry_q;
  logic [NUM_STAGES-1:0][NUM_OUTPUT_CHANNELS-1:0] entry_d;
  logic                                           overflow_error_q;
  logic                                           overflow_error_d;

  logic                           accepted;
  logic [NUM_OUTPUT_CHANNELS-1:0] inc_mask;
  logic [NUM_OUTPUT_CHANNELS-1:0] dec_mask;
  logic [NUM_OUTPUT_CHANNELS-1:0] hold_mask;
  logic [NUM_OUTPUT_CHANNELS-1:0] over_mask;

  assign accepted  = issue_valid & ~stall & ~quash;
  assign inc_mask  = accepted ? issue_oci : '0;
  assign dec_mask  = (~stall & ~quash) ? entry_q[LAST] : '0;
  // A stalled quash keeps the final-stage write alive; otherwise everything drains.
  assign hold_mask = stall ? entry_q[LAST] : '0;

  always_comb begin
    entry_d = entry_q;
    if (quash) begin
      for (int k = 0; k < LAST; k++) begin
        entry_d[k] = '0;
      end
      if (!stall) begin
        entry_d[LAST] = '0;
      end
    end else if (!stall) begin
      for (int k = LAST; k > 0; k--) begin
        entry_d[k] = entry_q[k-1];
      end
      entry_d[0] = inc_mask;
    end
  end

  always_comb begin
    overflow_error_d = overflow_error_q
                     | (|(inc_mask & output_channel_full_status))
                     | (|over_mask);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      entry_q          <= '0;
      overflow_error_q <= 1'b0;
    end else begin
      entry_q          <= entry_d;
      overflow_error_q <= overflow_error_d;
    end
  end

  generate
    for (genvar c = 0; c < NUM_OUTPUT_CHANNELS; c++) begin : g_channel
      output_channel_inflight_counter #(
        .CNT_W            (CNT_W),
        .OCC_W            (OCC_W),
        .SUM_W            (SUM_W),
        .DEPTH            (CHANNEL_BUFFER_DEPTH),
        .PESSIMISTIC_MODE (PESSIMISTIC_MODE)
      ) u_counter (
        .clock       (clock),
        .reset_n     (reset_n),
        .inc         (inc_mask[c]),
        .dec         (dec_mask[c]),
        .quash_load  (quash),
        .quash_value (hold_mask[c]),
        .occupancy   (output_channel_occupancy[c*OCC_W +: OCC_W]),
        .count       (inflight_count[c*CNT_W +: CNT_W]),
        .full        (output_channel_full_status[c]),
        .over        (over_mask[c])
      );
    end
  endgenerate

  assign overflow_error = overflow_error_q;

endmodule

`default_nettype wire
